// File: rtl/coef_fetch_pkg.sv
// Shared definitions for the coefficient fetch block: FSM encoding and default sizes.
package coef_fetch_pkg;

    localparam int DEF_WORDSIZE = 16;
    localparam int DEF_ADDRSIZE = 5;
    localparam int DEF_NUMADDR  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/coef_skid_fifo.sv
// Two-entry output FIFO for coefficient pairs. Entry 0 is always the head, so
// the outputs are plain registers and hold steady while the consumer stalls.
module coef_skid_fifo
    import coef_fetch_pkg::*;
#(
    parameter int WIDTH = DEF_WORDSIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_re,
    input  logic [WIDTH-1:0] push_im,
    input  logic             pop,
    output logic [1:0]       level,
    output logic             valid,
    output logic [WIDTH-1:0] head_re,
    output logic [WIDTH-1:0] head_im
);

    logic [WIDTH-1:0] re_reg  [2];
    logic [WIDTH-1:0] im_reg  [2];
    logic [WIDTH-1:0] re_next [2];
    logic [WIDTH-1:0] im_next [2];
    logic [1:0]       level_reg;
    logic [1:0]       level_next;
    logic [1:0]       wr_idx;
    logic             pop_ok;

    assign pop_ok     = pop & (level_reg != 2'd0);
    // A push lands in the first free slot after this cycle's pop has shifted the queue.
    assign wr_idx     = level_reg - {1'b0, pop_ok};
    assign level_next = wr_idx + {1'b0, push};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            assign re_next[gi] = (push && wr_idx == 2'(gi)) ? push_re :
                                 ((pop_ok && gi == 0) ? re_reg[1] : re_reg[gi]);
            assign im_next[gi] = (push && wr_idx == 2'(gi)) ? push_im :
                                 ((pop_ok && gi == 0) ? im_reg[1] : im_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                re_reg[i] <= '0;
                im_reg[i] <= '0;
            end
        end else begin
            level_reg <= level_next;
            for (int i = 0; i < 2; i++) begin
                re_reg[i] <= re_next[i];
                im_reg[i] <= im_next[i];
            end
        end
    end

    assign level   = level_reg;
    assign valid   = (level_reg != 2'd0);
    assign head_re = re_reg[0];
    assign head_im = im_reg[0];

endmodule

// File: rtl/coef_fetch.sv
// Coefficient pair fetcher: walks a strided address sequence through a registered
// ROM and streams pairs out. Optional conjugation enabled by COEF_FETCH_CONJ_EN.
module coef_fetch
    import coef_fetch_pkg::*;
#(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int ADDRSIZE = DEF_ADDRSIZE,
    parameter int NUMADDR  = DEF_NUMADDR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDRSIZE-1:0] base,
    input  logic [ADDRSIZE-1:0] stride,
    input  logic [ADDRSIZE:0]   count,
    input  logic                conj,
    output logic                busy,
    output logic                done,
    output logic                rom_cs,
    output logic [ADDRSIZE-1:0] rom_addr,
    input  logic [WORDSIZE-1:0] rom_data1,
    input  logic [WORDSIZE-1:0] rom_data2,
    output logic [WORDSIZE-1:0] out_re,
    output logic [WORDSIZE-1:0] out_im,
    output logic                out_valid,
    input  logic                out_ready
);

    state_t              state_reg, state_next;
    logic [ADDRSIZE-1:0] addr_reg, addr_next;
    logic [ADDRSIZE-1:0] stride_reg, stride_next;
    logic [ADDRSIZE:0]   left_reg, left_next;
    logic [ADDRSIZE:0]   count_eff;
    logic                inflight_reg, inflight_next;
    logic                issue;
    logic                pop;
    logic                fifo_valid;
    logic [1:0]          fifo_level;
    logic [2:0]          occupancy;
    logic [WORDSIZE-1:0] push_im;

    assign count_eff = (count > (ADDRSIZE+1)'(NUMADDR)) ? (ADDRSIZE+1)'(NUMADDR) : count;
    assign pop       = fifo_valid & out_ready;
    // Slots committed after this cycle: surviving FIFO entries plus the read in flight.
    assign occupancy = {1'b0, fifo_level} - {2'b0, pop} + {2'b0, inflight_reg};

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        stride_next   = stride_reg;
        left_next     = left_reg;
        issue         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    addr_next   = base;
                    stride_next = stride;
                    left_next   = count_eff;
                    state_next  = (count_eff == '0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (occupancy < 3'd2) begin
                    issue     = 1'b1;
                    addr_next = addr_reg + stride_reg;
                    left_next = left_reg - 1'b1;
                    if (left_reg == (ADDRSIZE+1)'(1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (occupancy == 3'd0) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        inflight_next = issue;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            stride_reg   <= '0;
            left_reg     <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            stride_reg   <= stride_next;
            left_reg     <= left_next;
            inflight_reg <= inflight_next;
        end
    end

`ifdef COEF_FETCH_CONJ_EN
    logic conj_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conj_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && start) begin
            conj_reg <= conj;
        end
    end

    // Plain two's-complement negate: the most negative code wraps onto itself.
    assign push_im = conj_reg ? -rom_data2 : rom_data2;
`else
    logic conj_unused;

    assign conj_unused = conj;
    assign push_im     = rom_data2;
`endif

    coef_skid_fifo #(
        .WIDTH (WORDSIZE)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (inflight_reg),
        .push_re (rom_data1),
        .push_im (push_im),
        .pop     (pop),
        .level   (fifo_level),
        .valid   (fifo_valid),
        .head_re (out_re),
        .head_im (out_im)
    );

    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_FINISH);
    assign rom_cs    = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign rom_addr  = addr_reg;
    assign out_valid = fifo_valid;

endmodule

// File: tb/tb_coef_fetch.sv
// Directed bench for coef_fetch with a behavioural registered ROM (re[i]=i, im[i]=0x100+i).
module tb_coef_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  base = '0;
    logic [4:0]  stride = '0;
    logic [5:0]  count = '0;
    logic        conj = 1'b0;
    logic        busy, done, rom_cs, out_valid;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data1 = '0;
    logic [15:0] rom_data2 = '0;
    logic [15:0] out_re, out_im;
    logic        out_ready = 1'b0;

    logic [15:0] rom_re [32];
    logic [15:0] rom_im [32];

    int checks = 0;
    int errors = 0;

    logic [15:0] got_re[$];
    logic [15:0] got_im[$];
    int          done_cnt, first_valid, last_xfer, done_cyc, stall_bad;
    logic        cs_seen;

    coef_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .stride    (stride),
        .count     (count),
        .conj      (conj),
        .busy      (busy),
        .done      (done),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data1 (rom_data1),
        .rom_data2 (rom_data2),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_cs) begin
            rom_data1 <= rom_re[rom_addr];
            rom_data2 <= rom_im[rom_addr];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one sequence for 60 cycles and records what came out; tests judge the record.
    // mode 0: ready high; mode 1: ready 1,0,0,1 repeating; mode 2: ready high plus a stray start.
    task automatic run_seq(input logic [4:0] b, input logic [4:0] s, input logic [5:0] c,
                           input logic cj, input int mode);
        logic        stalled;
        logic [15:0] hold_re, hold_im;
        got_re.delete();
        got_im.delete();
        done_cnt = 0; first_valid = -1; last_xfer = -1; done_cyc = -1;
        stall_bad = 0; cs_seen = 1'b0; stalled = 1'b0;
        hold_re = '0; hold_im = '0;
        base = b; stride = s; count = c; conj = cj;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        for (int cyc = 1; cyc <= 60; cyc++) begin
            start = 1'b0;
            if (mode == 2 && cyc == 2) begin
                start = 1'b1; base = 5'd20; count = 6'd6;
            end
            out_ready = (mode == 1) ? (((cyc % 4) == 0) || ((cyc % 4) == 3)) : 1'b1;
            if (rom_cs) cs_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stalled && (!out_valid || out_re !== hold_re || out_im !== hold_im)) stall_bad++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                got_re.push_back(out_re);
                got_im.push_back(out_im);
                last_xfer = cyc;
                $display("xfer cyc=%0d re=%h im=%h", cyc, out_re, out_im);
            end
            stalled = out_valid && !out_ready;
            hold_re = out_re;
            hold_im = out_im;
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_cs got %b exp 0", rom_cs); end
        checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", rom_addr); end
        checks++; if (out_re !== 16'h0 || out_im !== 16'h0) begin
            errors++; $display("FAIL reset_data got %h/%h exp 0/0", out_re, out_im);
        end
    endtask

    task automatic test_basic;
        run_seq(5'd0, 5'd1, 6'd4, 1'b0, 0);
        checks++; if (got_re.size() != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", got_re.size()); end
        for (int i = 0; i < 4 && i < got_re.size(); i++) begin
            checks++;
            if (got_re[i] !== 16'(i) || got_im[i] !== 16'(16'h100 + i)) begin
                errors++; $display("FAIL basic_pair%0d got %h/%h exp %h/%h", i, got_re[i], got_im[i], 16'(i), 16'(16'h100 + i));
            end
        end
        checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", first_valid); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt); end
        checks++; if (done_cyc != last_xfer + 1) begin
            errors++; $display("FAIL basic_done_timing got %0d exp %0d", done_cyc, last_xfer + 1);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_re [3];
        exp_re[0] = 16'd30; exp_re[1] = 16'd2; exp_re[2] = 16'd6;
        run_seq(5'd30, 5'd4, 6'd3, 1'b0, 0);
        checks++; if (got_re.size() != 3) begin errors++; $display("FAIL wrap_count got %0d exp 3", got_re.size()); end
        for (int i = 0; i < 3 && i < got_re.size(); i++) begin
            checks++;
            if (got_re[i] !== exp_re[i] || got_im[i] !== (16'h100 + exp_re[i])) begin
                errors++; $display("FAIL wrap_pair%0d got %h/%h exp %h/%h", i, got_re[i], got_im[i], exp_re[i], 16'h100 + exp_re[i]);
            end
        end
    endtask

    task automatic test_stall;
        run_seq(5'd5, 5'd1, 6'd8, 1'b0, 1);
        checks++; if (got_re.size() != 8) begin errors++; $display("FAIL stall_count got %0d exp 8", got_re.size()); end
        for (int i = 0; i < 8 && i < got_re.size(); i++) begin
            checks++;
            if (got_re[i] !== 16'(5 + i) || got_im[i] !== 16'(16'h105 + i)) begin
                errors++; $display("FAIL stall_pair%0d got %h/%h exp %h/%h", i, got_re[i], got_im[i], 16'(5 + i), 16'(16'h105 + i));
            end
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", stall_bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_zero;
        run_seq(5'd3, 5'd1, 6'd0, 1'b0, 0);
        checks++; if (done_cnt != 1 || done_cyc != 1) begin
            errors++; $display("FAIL zero_done got %0d pulses at %0d exp 1 at 1", done_cnt, done_cyc);
        end
        checks++; if (first_valid != -1 || got_re.size() != 0) begin
            errors++; $display("FAIL zero_valid got first=%0d n=%0d exp -1/0", first_valid, got_re.size());
        end
        checks++; if (cs_seen !== 1'b0) begin errors++; $display("FAIL zero_cs got %b exp 0", cs_seen); end
    endtask

    task automatic test_busy_ignore;
        run_seq(5'd0, 5'd2, 6'd3, 1'b0, 2);
        checks++; if (got_re.size() != 3) begin errors++; $display("FAIL ignore_count got %0d exp 3", got_re.size()); end
        for (int i = 0; i < 3 && i < got_re.size(); i++) begin
            checks++;
            if (got_re[i] !== 16'(2 * i)) begin
                errors++; $display("FAIL ignore_pair%0d got %h exp %h", i, got_re[i], 16'(2 * i));
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        bit hit = 1'b0;
        base = 5'd0; stride = 5'd1; count = 6'd10; conj = 1'b0; out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc < 40 && !hit; cyc++) begin
            if (out_valid && n == 2) begin
                hit = 1'b1;
                checks++; if (out_re !== 16'd2) begin errors++; $display("FAIL mid_third got %h exp 0002", out_re); end
                rst_n = 1'b0;
                #1;
                checks++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rom_cs !== 1'b0) begin
                    errors++; $display("FAIL mid_ctrl got busy=%b done=%b valid=%b cs=%b exp 0000", busy, done, out_valid, rom_cs);
                end
                checks++; if (rom_addr !== 5'd0 || out_re !== 16'h0 || out_im !== 16'h0) begin
                    errors++; $display("FAIL mid_data got addr=%h re=%h im=%h exp 0", rom_addr, out_re, out_im);
                end
            end else begin
                if (out_valid) n++;
                step();
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL mid_reached got %0d transfers exp 2", n); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_held got done=%b busy=%b exp 0/0", done, busy);
            end
        end
        rst_n = 1'b1;
        step();
        run_seq(5'd0, 5'd1, 6'd2, 1'b0, 0);
        checks++; if (got_re.size() != 2) begin errors++; $display("FAIL mid_restart_count got %0d exp 2", got_re.size()); end
        for (int i = 0; i < 2 && i < got_re.size(); i++) begin
            checks++;
            if (got_re[i] !== 16'(i)) begin errors++; $display("FAIL mid_restart_pair%0d got %h exp %h", i, got_re[i], 16'(i)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL mid_restart_done got %0d exp 1", done_cnt); end
    endtask

    task automatic test_conj;
        logic [15:0] exp_im0, exp_im1;
`ifdef COEF_FETCH_CONJ_EN
        exp_im0 = 16'hFFFB;
        exp_im1 = 16'h8000;
`else
        exp_im0 = 16'h0005;
        exp_im1 = 16'h8000;
`endif
        rom_im[0] = 16'h0005;
        rom_im[1] = 16'h8000;
        run_seq(5'd0, 5'd1, 6'd2, 1'b1, 0);
        checks++; if (got_im.size() != 2) begin errors++; $display("FAIL conj_count got %0d exp 2", got_im.size()); end
        if (got_im.size() == 2) begin
            checks++; if (got_im[0] !== exp_im0) begin errors++; $display("FAIL conj_im0 got %h exp %h", got_im[0], exp_im0); end
            checks++; if (got_im[1] !== exp_im1) begin errors++; $display("FAIL conj_im1 got %h exp %h", got_im[1], exp_im1); end
            checks++; if (got_re[0] !== 16'd0 || got_re[1] !== 16'd1) begin
                errors++; $display("FAIL conj_re got %h/%h exp 0000/0001", got_re[0], got_re[1]);
            end
        end
        rom_im[0] = 16'h0100;
        rom_im[1] = 16'h0101;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom_re[i] = 16'(i);
            rom_im[i] = 16'(16'h100 + i);
        end
        rst_n = 1'b0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_wrap();
        test_stall();
        test_zero();
        test_busy_ignore();
        test_reset_mid();
        test_conj();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
